// File: rtl/downcounter_timer.sv
// rtl/downcounter_timer.sv - loadable down-counter/timer with one-shot and auto-reload modes
//
// Purpose:
//   Counts q from a programmed value down to 0. When the count reaches 0 it
//   pulses tc. In one-shot mode it then stops in DONE. In auto-reload mode it
//   reloads from reload_reg and keeps counting. Used as a delay or interval timer.
//   After reset q and reload_reg are all-ones, so the default count is 2^WIDTH-1 .. 0.
//
// Parameters:
//   WIDTH        counter width
//   PRESCALE     clk cycles per count tick (>= 1); used only with DNCNT_PRESCALE_EN
//
// Configuration macro:
//   DNCNT_PRESCALE_EN  defined   -> internal prescaler; one tick every PRESCALE cycles in RUN
//                      undefined -> one tick every clk cycle in RUN
//
// Ports:
//   clk          in   1      clock, posedge
//   rst          in   1      synchronous reset, active-high
//   load         in   1      load load_val into q and reload_reg, go IDLE
//   load_val     in   WIDTH  value captured on load
//   start        in   1      resume from IDLE, or restart from DONE
//   stop         in   1      pause counting (RUN -> IDLE); q holds
//   auto_reload  in   1      1: reload on terminal count; 0: one-shot
//   q            out  WIDTH  current count (registered)
//   busy         out  1      high while in RUN
//   tc           out  1      one-cycle pulse in the cycle q first shows 0 after a tick
//   done         out  1      high while in DONE (one-shot expired)

module downcounter_timer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] reload_n;
  logic [WIDTH-1:0] q_n;
  logic [WIDTH-1:0] nxt;
  logic             tc_n;
  logic             tick;

  // A zero prescale would never produce a tick.
  generate
    if (PRESCALE < 1) begin : g_prescale_check
      $error("downcounter_timer: PRESCALE must be >= 1");
    end
  endgenerate

`ifdef DNCNT_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE + 1);

  logic [PW-1:0] pcnt;
  logic          pclr;

  // start is ignored while in RUN, so it clears the prescaler only when it is
  // accepted. A running interval is therefore not disturbed by a redundant start.
  assign pclr = load | stop | (start & (state != RUN));

  // The tick fires on the PRESCALE-th cycle after the counter was cleared.
  // This makes the first decrement come PRESCALE cycles after start.
  assign tick = (state == RUN) && (pcnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (rst || pclr) begin
      pcnt <= '0;
    end else if (state == RUN) begin
      pcnt <= tick ? '0 : pcnt + PW'(1);
    end
  end
`else
  assign tick = (state == RUN);
`endif

  // Reaching 0 reloads instead of underflowing. q wraps to all-ones only when
  // reload_reg itself is all-ones.
  assign nxt = (q == '0) ? reload_reg : q - WIDTH'(1);

  // Next-state logic. Priority is load > stop > start > count; rst is applied
  // in the register process. A stop blocks a start in every state.
  always_comb begin
    state_n  = state;
    q_n      = q;
    reload_n = reload_reg;
    tc_n     = 1'b0;
    if (load) begin
      q_n      = load_val;
      reload_n = load_val;
      state_n  = IDLE;
    end else if (stop) begin
      if (state == RUN) begin
        state_n = IDLE;
      end
    end else if (start) begin
      case (state)
        IDLE:    state_n = RUN;
        DONE: begin
          state_n = RUN;
          q_n     = reload_reg;
        end
        default: state_n = state;
      endcase
    end else if (tick) begin
      q_n  = nxt;
      tc_n = (nxt == '0);
      if ((nxt == '0) && !auto_reload) begin
        state_n = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      q          <= '1;
      reload_reg <= '1;
      tc         <= 1'b0;
    end else begin
      state      <= state_n;
      q          <= q_n;
      reload_reg <= reload_n;
      tc         <= tc_n;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_downcounter_timer.sv
// tb/tb_downcounter_timer.sv - scoreboard testbench for downcounter_timer
module tb_downcounter_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       auto_reload = 1'b0;
  logic [3:0] q;
  logic       busy;
  logic       tc;
  logic       done;

  downcounter_timer #(.WIDTH(4), .PRESCALE(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_val    (load_val),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
    .q           (q),
    .busy        (busy),
    .tc          (tc),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         phase;
    int         id;
    logic [3:0] q;
    logic       busy;
    logic       tc;
    logic       done;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   phase = 0;
  int   next_id = 0;
  int   vectors = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: after every posedge the DUT presents a new output set. It is
  // checked at the following negedge against the entry tagged for that cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      vectors = vectors + 1;
      if (e.cyc != cyc) begin
        fails = fails + 1;
        $display("FAIL p%0d v%0d missed: expected at cycle %0d, checked at %0d",
                 e.phase, e.id, e.cyc, cyc);
      end else if (q !== e.q || busy !== e.busy || tc !== e.tc || done !== e.done) begin
        fails = fails + 1;
        $display("FAIL p%0d v%0d got q=%0d busy=%b tc=%b done=%b, expected q=%0d busy=%b tc=%b done=%b",
                 e.phase, e.id, q, busy, tc, done, e.q, e.busy, e.tc, e.done);
      end
    end
  end

  // Drive one cycle of inputs at the negedge. Push the outputs expected after the next posedge.
  task automatic step(input logic rs, input logic ld, input logic [3:0] lv,
                      input logic st, input logic sp, input logic ar,
                      input logic [3:0] eq, input logic eb, input logic et, input logic ed);
    exp_t x;
    @(negedge clk);
    rst = rs; load = ld; load_val = lv; start = st; stop = sp; auto_reload = ar;
    x.cyc = cyc + 1; x.phase = phase; x.id = next_id;
    x.q = eq; x.busy = eb; x.tc = et; x.done = ed;
    next_id = next_id + 1;
    sb.push_back(x);
  endtask

  // Shorthand for an idle cycle that only lets the counter run.
  task automatic run(input logic ar, input logic [3:0] eq, input logic eb,
                     input logic et, input logic ed);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, ar, eq, eb, et, ed);
  endtask

  initial begin
`ifdef DNCNT_PRESCALE_EN
    // Prescaled one-shot from 2: one change every 4 clocks.
    phase = 6;
    step(1, 0, 4'd0, 0, 0, 0, 4'd15, 0, 0, 0);
    step(0, 1, 4'd2, 0, 0, 0, 4'd2, 0, 0, 0);
    step(0, 0, 4'd0, 1, 0, 0, 4'd2, 1, 0, 0);
    for (int i = 0; i < 3; i++) run(0, 4'd2, 1, 0, 0);
    run(0, 4'd1, 1, 0, 0);
    for (int i = 0; i < 3; i++) run(0, 4'd1, 1, 0, 0);
    run(0, 4'd0, 0, 1, 1);
    run(0, 4'd0, 0, 0, 1);
    run(0, 4'd0, 0, 0, 1);
`else
    // 1: reset, one-shot count 15..0, then hold in DONE.
    phase = 1;
    step(1, 0, 4'd0, 0, 0, 0, 4'd15, 0, 0, 0);
    step(0, 0, 4'd0, 1, 0, 0, 4'd15, 1, 0, 0);
    for (int i = 14; i >= 1; i--) run(0, 4'(i), 1, 0, 0);
    run(0, 4'd0, 0, 1, 1);
    for (int i = 0; i < 3; i++) run(0, 4'd0, 0, 0, 1);

    // 5: restart from DONE reloads 15; reset while running at q=4.
    phase = 5;
    step(0, 0, 4'd0, 1, 0, 0, 4'd15, 1, 0, 0);
    for (int i = 14; i >= 4; i--) run(0, 4'(i), 1, 0, 0);
    step(1, 0, 4'd0, 0, 0, 0, 4'd15, 0, 0, 0);
    run(0, 4'd15, 0, 0, 0);

    // 2: load 5 and auto-reload; the period is 6 cycles and done stays low.
    phase = 2;
    step(0, 1, 4'd5, 0, 0, 1, 4'd5, 0, 0, 0);
    step(0, 0, 4'd0, 1, 0, 1, 4'd5, 1, 0, 0);
    for (int p = 0; p < 2; p++) begin
      for (int v = 4; v >= 0; v--) run(1, 4'(v), 1, (v == 0), 0);
      run(1, 4'd5, 1, 0, 0);
    end

    // 3: stop at q=9, hold for 10 cycles, then resume.
    phase = 3;
    step(0, 1, 4'd12, 0, 0, 0, 4'd12, 0, 0, 0);
    step(0, 0, 4'd0, 1, 0, 0, 4'd12, 1, 0, 0);
    run(0, 4'd11, 1, 0, 0);
    run(0, 4'd10, 1, 0, 0);
    run(0, 4'd9, 1, 0, 0);
    step(0, 0, 4'd0, 0, 1, 0, 4'd9, 0, 0, 0);
    for (int i = 0; i < 10; i++) run(0, 4'd9, 0, 0, 0);
    step(0, 0, 4'd0, 1, 0, 0, 4'd9, 1, 0, 0);
    run(0, 4'd8, 1, 0, 0);

    // 4: load while running at 7; start+stop together; reload of 0.
    phase = 4;
    run(0, 4'd7, 1, 0, 0);
    step(0, 1, 4'd3, 0, 0, 0, 4'd3, 0, 0, 0);
    step(0, 0, 4'd0, 1, 1, 0, 4'd3, 0, 0, 0);
    run(0, 4'd3, 0, 0, 0);
    step(0, 1, 4'd0, 0, 0, 1, 4'd0, 0, 0, 0);
    step(0, 0, 4'd0, 1, 0, 1, 4'd0, 1, 0, 0);
    for (int i = 0; i < 4; i++) run(1, 4'd0, 1, 1, 0);
    step(0, 0, 4'd0, 0, 1, 1, 4'd0, 0, 0, 0);
    // One-shot from 0 finishes on the first tick.
    step(0, 0, 4'd0, 1, 0, 0, 4'd0, 1, 0, 0);
    run(0, 4'd0, 0, 1, 1);
    // A load together with start wins; it also clears done.
    step(0, 1, 4'd2, 1, 0, 0, 4'd2, 0, 0, 0);
    step(0, 0, 4'd0, 1, 0, 0, 4'd2, 1, 0, 0);
    run(0, 4'd1, 1, 0, 0);
    run(0, 4'd0, 0, 1, 1);
    run(0, 4'd0, 0, 0, 1);
`endif

    @(negedge clk);
    rst = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      fails = fails + 1;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
